// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM states
//   - Def*        : default parameter values
//   - rr_next     : modulo increment of the round-robin pointer
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } arb_state_e;

   localparam int unsigned DefNumReq = 4;
   localparam int unsigned DefDataW  = 8;
   localparam int unsigned DefCntW   = 16;

   // Next round-robin start position: (ptr + 1) mod n, for ptr < n.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   base  : index with highest priority; search runs upward and wraps
//   gnt   : one-hot pick (zero when nothing requested)
//   found : any request present
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] base,
   output logic [N-1:0]     gnt,
   output logic             found
);

   always_comb begin
      int unsigned      idx;
      logic [PTR_W-1:0] sel;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         // base < N, so a single subtraction is enough to wrap
         idx = 32'(base) + i;
         if (idx >= N) idx = idx - N;
         sel = PTR_W'(idx);
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NUM_REQ
// requesters. A grant is held until the owner's last beat is written; the
// write path (data mux, strobe, ready) is combinational from the granted input.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid_i   : per-requester beat valid
//   req_data_i    : per-requester beat, requester k at [k*DATA_W +: DATA_W]
//   req_last_i    : final beat of a packet
//   req_ready_o   : beat accepted this cycle when ANDed with valid
//   fifo_full_i   : FIFO full flag
//   fifo_wr_en_o  : FIFO write strobe
//   fifo_data_o   : FIFO write data
//   grant_o       : one-hot current owner, zero when idle
//   busy_o        : a packet is in progress
// Optional (FIFO_WR_ARBITER_STATS_EN defined):
//   stats_clr_i   : synchronous clear of all packet counters
//   pkt_cnt_o     : per-requester saturating packet counts, CNT_W bits each
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DefNumReq,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_wr_en_o,
   output logic [DATA_W-1:0]         fifo_data_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o
`ifdef FIFO_WR_ARBITER_STATS_EN
   ,
   input  logic                      stats_clr_i,
   output logic [NUM_REQ*CNT_W-1:0]  pkt_cnt_o
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_found;
   logic [PTR_W-1:0]   gnt_idx;
   logic               wr_en;

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (req_valid_i),
      .base  (rr_ptr_q),
      .gnt   (pick_gnt),
      .found (pick_found)
   );

   // One-hot grant to index; zero grant maps to index 0 but is only used in StBusy.
   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) gnt_idx = PTR_W'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      req_ready_o  = '0;
      wr_en        = 1'b0;
      fifo_data_o  = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick_gnt;
               state_d = StBusy;
            end
         end
         StBusy: begin
            req_ready_o = grant_q & {NUM_REQ{~fifo_full_i}};
            fifo_data_o = req_data_i[32'(gnt_idx)*DATA_W +: DATA_W];
            wr_en       = req_valid_i[gnt_idx] & ~fifo_full_i;
            if (wr_en && req_last_i[gnt_idx]) begin
               rr_ptr_d = PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
               grant_d  = '0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
      end
   end

   assign fifo_wr_en_o = wr_en;
   assign grant_o      = grant_q;
   assign busy_o       = (state_q == StBusy);

`ifdef FIFO_WR_ARBITER_STATS_EN
   logic last_wr;
   assign last_wr = wr_en & req_last_i[gnt_idx];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (stats_clr_i) begin
            cnt_q <= '0;
         end else if (last_wr && grant_q[k] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign pkt_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
   end
`endif

   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_no_wr_when_full: assert property (@(posedge clk) disable iff (rst)
                                       !(wr_en && fifo_full_i));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8).
// Define FIFO_WR_ARBITER_STATS_EN for both bench and RTL to exercise the counters.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 16;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_data;
   logic [N-1:0]    grant;
   logic            busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
   logic            stats_clr;
   logic [N*CW-1:0] pkt_cnt;
`endif

   int errors = 0;
   int checks = 0;

   fifo_wr_arbiter #(
      .NUM_REQ (N),
      .DATA_W  (DW),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_last_i   (req_last),
      .req_ready_o  (req_ready),
      .fifo_full_i  (fifo_full),
      .fifo_wr_en_o (fifo_wr_en),
      .fifo_data_o  (fifo_data),
      .grant_o      (grant),
      .busy_o       (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
      ,
      .stats_clr_i  (stats_clr),
      .pkt_cnt_o    (pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic idle_inputs();
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
      stats_clr = 1'b0;
`endif
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      req_valid = '1;
      @(negedge clk);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
      checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", fifo_data); end
      next_cycle();
      req_valid = '0;
      rst = 1'b0;
   endtask

   // Requester 2 sends A1,A2,A3; leaves rr_ptr at 3.
   task automatic test_single();
      logic [7:0] beats [3];
      beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
      req_valid[2] = 1'b1;
      req_data[2*DW +: DW] = beats[0];
      @(negedge clk);
      checks++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL single_idle: got grant=%b wr=%b rdy=%b want 0000/0/0000", grant, fifo_wr_en, req_ready);
      end
      next_cycle();
      for (int b = 0; b < 3; b++) begin
         req_data[2*DW +: DW] = beats[b];
         req_last[2] = (b == 2);
         @(negedge clk);
         checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant%0d: got %b want 0100", b, grant); end
         checks++; if (fifo_wr_en !== 1'b1 || fifo_data !== beats[b]) begin
            errors++; $display("FAIL single_write%0d: got wr=%b data=%h want 1/%h", b, fifo_wr_en, fifo_data, beats[b]);
         end
         checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready%0d: got %b want 0100", b, req_ready); end
         next_cycle();
      end
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      checks++; if (grant !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL single_end: got grant=%b busy=%b wr=%b want 0000/0/0", grant, busy, fifo_wr_en);
      end
      next_cycle();
   endtask

   // rr_ptr=3, requests on 0 and 3: 3 first, then 0; afterwards rr_ptr=1.
   task automatic test_wrap();
      req_valid = 4'b1001;
      req_last  = 4'b1001;
      req_data[0*DW +: DW] = 8'hC0;
      req_data[3*DW +: DW] = 8'hD3;
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b1000 || fifo_data !== 8'hD3) begin
         errors++; $display("FAIL wrap_first: got grant=%b data=%h want 1000/d3", grant, fifo_data);
      end
      next_cycle();
      req_valid[3] = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL wrap_bubble: got grant=%b wr=%b want 0000/0", grant, fifo_wr_en);
      end
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b0001 || fifo_data !== 8'hC0 || fifo_wr_en !== 1'b1) begin
         errors++; $display("FAIL wrap_second: got grant=%b data=%h wr=%b want 0001/c0/1", grant, fifo_data, fifo_wr_en);
      end
      next_cycle();
      // rr_ptr should now be 1: with 0 and 1 requesting, 1 wins
      req_valid = 4'b0011;
      req_last  = 4'b0011;
      req_data[1*DW +: DW] = 8'hC1;
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b0010 || fifo_data !== 8'hC1) begin
         errors++; $display("FAIL wrap_ptr: got grant=%b data=%h want 0010/c1", grant, fifo_data);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   // Full held for 5 cycles on beat 1 of a 4-beat packet from requester 1.
   task automatic test_backpressure();
      req_valid[1] = 1'b1;
      req_data[1*DW +: DW] = 8'hB0;
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data !== 8'hB0) begin
         errors++; $display("FAIL bp_first: got grant=%b wr=%b data=%h want 0010/1/b0", grant, fifo_wr_en, fifo_data);
      end
      next_cycle();
      req_data[1*DW +: DW] = 8'hB1;
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold%0d: got wr=%b rdy=%b want 0/0000", c, fifo_wr_en, req_ready);
         end
         checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_grant%0d: got %b want 0010", c, grant); end
         next_cycle();
      end
      fifo_full = 1'b0;
      for (int b = 1; b < 4; b++) begin
         req_data[1*DW +: DW] = 8'hB0 + 8'(b);
         req_last[1] = (b == 3);
         @(negedge clk);
         checks++; if (fifo_wr_en !== 1'b1 || fifo_data !== 8'hB0 + 8'(b) || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_beat%0d: got wr=%b data=%h rdy=%b want 1/%h/0010", b, fifo_wr_en, fifo_data,
                               req_ready, 8'hB0 + 8'(b));
         end
         next_cycle();
      end
      idle_inputs();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end: got busy=%b want 0", busy); end
      next_cycle();
   endtask

   // Async reset during beat 2 of 4 from requester 3, then re-arbitration from rr_ptr=0.
   task automatic test_async_reset();
      req_valid[3] = 1'b1;
      req_data[3*DW +: DW] = 8'hE0;
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b1000 || fifo_data !== 8'hE0) begin
         errors++; $display("FAIL ar_first: got grant=%b data=%h want 1000/e0", grant, fifo_data);
      end
      next_cycle();
      req_data[3*DW +: DW] = 8'hE1;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (grant !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000
                    || fifo_data !== 8'h00) begin
         errors++; $display("FAIL ar_zero: got grant=%b busy=%b wr=%b rdy=%b data=%h want all zero", grant, busy,
                            fifo_wr_en, req_ready, fifo_data);
      end
      rst = 1'b0;
      req_valid = 4'b1010;
      req_last  = 4'b1010;
      req_data[1*DW +: DW] = 8'h51;
      req_data[3*DW +: DW] = 8'h53;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle: got busy=%b want 0", busy); end
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b0010 || fifo_data !== 8'h51) begin
         errors++; $display("FAIL ar_regrant: got grant=%b data=%h want 0010/51", grant, fifo_data);
      end
      next_cycle();
      req_valid[1] = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++; if (grant !== 4'b1000 || fifo_data !== 8'h53) begin
         errors++; $display("FAIL ar_next: got grant=%b data=%h want 1000/53", grant, fifo_data);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   // All four requesters continuously valid with 2-beat packets.
   task automatic test_fairness();
      int         b [N];
      int         order [$];
      logic [7:0] writes [$];
      logic [N-1:0] prev_grant;
      logic [N-1:0] acc;
      int         exp_order [5];
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      prev_grant = '0;
      for (int k = 0; k < N; k++) b[k] = 0;
      req_valid = '1;
      for (int cyc = 0; cyc < 80 && writes.size() < 10; cyc++) begin
         for (int k = 0; k < N; k++) begin
            req_data[k*DW +: DW] = 8'(16 * k + b[k]);
            req_last[k] = (b[k] == 1);
         end
         @(negedge clk);
         if (fifo_wr_en === 1'b1) writes.push_back(fifo_data);
         if (grant !== prev_grant && grant !== '0) begin
            for (int k = 0; k < N; k++) if (grant[k]) order.push_back(k);
         end
         prev_grant = grant;
         acc = req_ready & req_valid;
         next_cycle();
         for (int k = 0; k < N; k++) if (acc[k]) b[k] = 1 - b[k];
      end
      idle_inputs();
      checks++; if (order.size() < 5 || writes.size() < 10) begin
         errors++; $display("FAIL fair_count: got grants=%0d writes=%0d want >=5 and 10", order.size(), writes.size());
      end else begin
         for (int p = 0; p < 5; p++) begin
            checks++; if (order[p] != exp_order[p]) begin
               errors++; $display("FAIL fair_order%0d: got %0d want %0d", p, order[p], exp_order[p]);
            end
            for (int bb = 0; bb < 2; bb++) begin
               checks++; if (writes[2*p+bb] !== 8'(16 * exp_order[p] + bb)) begin
                  errors++; $display("FAIL fair_data%0d: got %h want %h", 2*p+bb, writes[2*p+bb],
                                     8'(16 * exp_order[p] + bb));
               end
            end
         end
      end
      next_cycle();
   endtask

`ifdef FIFO_WR_ARBITER_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid[1] = 1'b1;
      req_last[1]  = 1'b1;
      req_data[1*DW +: DW] = 8'h77;
      for (int c = 0; c < 6; c++) next_cycle();
      req_valid = '0;
      @(negedge clk);
      checks++; if (pkt_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin
         errors++; $display("FAIL stats_count: got %h want %h", pkt_cnt, {16'd0, 16'd0, 16'd3, 16'd0});
      end
      next_cycle();
      req_valid[1] = 1'b1;
      next_cycle();
      stats_clr = 1'b1;
      @(negedge clk);
      checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stats_lastwr: got %b want 1", fifo_wr_en); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL stats_clear: got %h want 0", pkt_cnt); end
      next_cycle();
   endtask
`endif

   // Random protocol-compliant traffic against a transaction-level model.
   task automatic test_random();
      logic         hv [N];
      logic [7:0]   hd [N];
      logic         hl [N];
      int           m_owner;
      int           m_ptr;
      logic [N-1:0] e_grant, e_ready;
      logic         e_wr;
      logic [7:0]   e_data;
      logic         found;
      do_reset();
      m_owner = -1;
      m_ptr   = 0;
      for (int k = 0; k < N; k++) begin
         hv[k] = ($urandom_range(0, 1) == 1);
         hd[k] = 8'($urandom);
         hl[k] = ($urandom_range(0, 2) == 0);
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < N; k++) begin
            req_valid[k] = hv[k];
            req_data[k*DW +: DW] = hd[k];
            req_last[k] = hl[k];
         end
         fifo_full = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         e_grant = '0; e_ready = '0; e_wr = 1'b0; e_data = 8'h00;
         if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_ready = fifo_full ? '0 : e_grant;
            e_wr    = hv[m_owner] && !fifo_full;
            e_data  = hd[m_owner];
         end
         checks++; if (grant !== e_grant) begin errors++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, e_grant); end
         checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, m_owner >= 0); end
         checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, e_ready); end
         checks++; if (fifo_wr_en !== e_wr) begin errors++; $display("FAIL rnd_wr@%0d: got %b want %b", cyc, fifo_wr_en, e_wr); end
         checks++; if (fifo_data !== e_data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, fifo_data, e_data); end
         if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (!found && hv[(m_ptr + i) % N]) begin
                  m_owner = (m_ptr + i) % N;
                  found   = 1'b1;
               end
            end
         end else if (e_wr && hl[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
         for (int k = 0; k < N; k++) begin
            if ((hv[k] && e_ready[k]) || !hv[k]) begin
               hv[k] = ($urandom_range(0, 2) != 0);
               hd[k] = 8'($urandom);
               hl[k] = ($urandom_range(0, 2) == 0);
            end
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_async_reset();
      test_fairness();
`ifdef FIFO_WR_ARBITER_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
